// File: rtl/filter_acc_pkg.sv
// Shared widths and saturation limits for the filter accumulator.
// Optional feature: define FILTER_ACC_SAT_EN to saturate instead of wrap on overflow.
package filter_acc_pkg;

  localparam int D_W = 16;
  localparam int Q_W = 20;

  localparam logic [Q_W-1:0] Q_MAX = 20'h7FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 20'h80000;

  // Replicates the sample's sign bit up to the accumulator width
  function automatic logic [Q_W-1:0] sign_extend(input logic [D_W-1:0] sample);
    return {{(Q_W-D_W){sample[D_W-1]}}, sample};
  endfunction

endpackage

// File: rtl/filter_acc_adder.sv
// Combinational datapath: sign-extend, add, detect signed overflow and optionally saturate.
// Saturation is selected by FILTER_ACC_SAT_EN; default build wraps modulo 2^Q_W.
module filter_acc_adder
  import filter_acc_pkg::*;
(
  input  logic [Q_W-1:0] acc,
  input  logic [D_W-1:0] sample,
  output logic [Q_W-1:0] sample_ext,
  output logic [Q_W-1:0] sum,
  output logic           overflow
);

  logic [Q_W-1:0] raw_sum;

  always_comb begin
    sample_ext = sign_extend(sample);
    raw_sum    = acc + sample_ext;
    // Overflow only when like-signed operands produce an opposite-signed result
    overflow   = (acc[Q_W-1] == sample_ext[Q_W-1]) && (raw_sum[Q_W-1] != acc[Q_W-1]);
`ifdef FILTER_ACC_SAT_EN
    if (overflow) begin
      sum = acc[Q_W-1] ? Q_MIN : Q_MAX;
    end else begin
      sum = raw_sum;
    end
`else
    sum = raw_sum;
`endif
  end

endmodule

// File: rtl/filter_accumulator.sv
// Registered signed accumulator with load, clock enable and sticky overflow flag.
// Build option FILTER_ACC_SAT_EN (handled in filter_acc_adder) saturates instead of wrapping.
module filter_accumulator
  import filter_acc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           load,
  input  logic [D_W-1:0] D,
  output logic [Q_W-1:0] Q,
  output logic           ovf
);

  logic [Q_W-1:0] q_q, q_d;
  logic           ovf_q, ovf_d;
  logic [Q_W-1:0] d_ext;
  logic [Q_W-1:0] add_sum;
  logic           add_ovf;

  filter_acc_adder u_adder (
    .acc        (q_q),
    .sample     (D),
    .sample_ext (d_ext),
    .sum        (add_sum),
    .overflow   (add_ovf)
  );

  // Load wins over accumulate; a load also clears the sticky flag
  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (enable) begin
      if (load) begin
        q_d   = d_ext;
        ovf_d = 1'b0;
      end else begin
        q_d   = add_sum;
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_filter_accumulator.sv
// Self-checking bench for filter_accumulator: fixed vector tables, corner-case
// sequences and randomized traffic compared against an integer reference model.
module tb_filter_accumulator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] D;
  logic [19:0] Q;
  logic        ovf;

  int checks_total;
  int checks_passed;

  // Reference model state kept as plain signed integers
  int q_m;
  bit ovf_m;

  typedef struct {
    bit          en;
    bit          ld;
    logic [15:0] d;
    logic [19:0] exp_q;
    bit          exp_ovf;
  } vec_t;

  vec_t seq_tab[5];
  vec_t prio_tab[8];

  filter_accumulator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .load   (load),
    .D      (D),
    .Q      (Q),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelStep(input bit en, input bit ld, input logic [15:0] d);
    int s;
    if (!en) return;
    if (ld) begin
      q_m   = int'($signed(d));
      ovf_m = 1'b0;
    end else begin
      s = q_m + int'($signed(d));
      if (s > 524287 || s < -524288) begin
        ovf_m = 1'b1;
`ifdef FILTER_ACC_SAT_EN
        s = (s > 0) ? 524287 : -524288;
`else
        s = (s > 0) ? s - 1048576 : s + 1048576;
`endif
      end
      q_m = s;
    end
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input logic [15:0] d);
    enable = en;
    load   = ld;
    D      = d;
    @(posedge clk);
    #1;
    modelStep(en, ld, d);
  endtask

  task automatic checkOutput(input string name, input logic [19:0] exp_q, input logic exp_ovf);
    checks_total++;
    if (Q !== exp_q) $display("[TB] FAIL %s: Q got 0x%05h expected 0x%05h", name, Q, exp_q);
    else checks_passed++;
    checks_total++;
    if (ovf !== exp_ovf) $display("[TB] FAIL %s: ovf got %b expected %b", name, ovf, exp_ovf);
    else checks_passed++;
  endtask

  task automatic checkModel(input string name);
    logic [19:0] exp_q;
    exp_q = q_m[19:0];
    checkOutput(name, exp_q, ovf_m);
  endtask

  initial begin
    logic [19:0] held_q;
    logic [15:0] rd;
    bit          ren, rld;
    checks_total  = 0;
    checks_passed = 0;
    q_m    = 0;
    ovf_m  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    D      = 16'h0000;
    rst_n  = 1'b0;

    seq_tab[0] = '{1'b1, 1'b1, 16'h000A, 20'h0000A, 1'b0};
    seq_tab[1] = '{1'b1, 1'b0, 16'hFFFF, 20'h00009, 1'b0};
    seq_tab[2] = '{1'b1, 1'b0, 16'h0334, 20'h0033D, 1'b0};
    seq_tab[3] = '{1'b1, 1'b0, 16'hFFFF, 20'h0033C, 1'b0};
    seq_tab[4] = '{1'b1, 1'b0, 16'hAA44, 20'hFAD80, 1'b0};

    prio_tab[0] = '{1'b1, 1'b1, 16'h0000, 20'h00000, 1'b0};
    prio_tab[1] = '{1'b1, 1'b1, 16'h0000, 20'h00000, 1'b0};
    prio_tab[2] = '{1'b1, 1'b1, 16'h0000, 20'h00000, 1'b0};
    prio_tab[3] = '{1'b1, 1'b0, 16'h0001, 20'h00001, 1'b0};
    prio_tab[4] = '{1'b1, 1'b0, 16'h0001, 20'h00002, 1'b0};
    prio_tab[5] = '{1'b1, 1'b0, 16'h0001, 20'h00003, 1'b0};
    prio_tab[6] = '{1'b0, 1'b1, 16'h1234, 20'h00003, 1'b0};
    prio_tab[7] = '{1'b1, 1'b0, 16'h0001, 20'h00004, 1'b0};

    // Reset held for 10 cycles
    #1;
    checkOutput("reset_immediate", 20'h00000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset_10cyc", 20'h00000, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(seq_tab[i].en, seq_tab[i].ld, seq_tab[i].d);
      checkOutput($sformatf("seq_%0d", i), seq_tab[i].exp_q, seq_tab[i].exp_ovf);
    end

    // Enable low: state must hold even with load and D toggling
    held_q = Q;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'(i % 2), 16'($urandom));
      checkOutput($sformatf("hold_%0d", i), held_q, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(prio_tab[i].en, prio_tab[i].ld, prio_tab[i].d);
      checkOutput($sformatf("prio_%0d", i), prio_tab[i].exp_q, prio_tab[i].exp_ovf);
    end

    // Asynchronous reset asserted between edges
    applyStimulus(1'b1, 1'b0, 16'h0100);
    checkOutput("pre_async", 20'h00104, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_now", 20'h00000, 1'b0);
    enable = 1'b1;
    load   = 1'b0;
    D      = 16'h0055;
    @(posedge clk);
    #1;
    checkOutput("async_reset_held", 20'h00000, 1'b0);
    #2 rst_n = 1'b1;
    q_m   = 0;
    ovf_m = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0005);
    checkOutput("resume_after_reset", 20'h00005, 1'b0);

    // Positive overflow: 0x7FFF loaded then accumulated 16 times
    applyStimulus(1'b1, 1'b1, 16'h7FFF);
    checkOutput("ovf_load", 20'h07FFF, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h7FFF);
      checkModel($sformatf("ovf_acc_%0d", i));
    end
`ifdef FILTER_ACC_SAT_EN
    checkOutput("ovf_final_sat", 20'h7FFFF, 1'b1);
`else
    checkOutput("ovf_final_wrap", 20'h87FEF, 1'b1);
`endif
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkModel("ovf_sticky");
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkModel("ovf_hold");
    // Negative overflow from the bottom of the range
    applyStimulus(1'b1, 1'b1, 16'h8000);
    checkOutput("ovf_clear_by_load", 20'hF8000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h8000);
      checkModel($sformatf("neg_ovf_acc_%0d", i));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      ren = ($urandom % 8) != 0;
      rld = ($urandom % 12) == 0;
      rd  = 16'($urandom);
      if (($urandom % 4) == 0) rd = ($urandom % 2) ? 16'h7FFF : 16'h8000;
      applyStimulus(ren, rld, rd);
      checkModel($sformatf("rand_%0d", i));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
